rob_wb_collector: RTL and testbench
===================================

Name: rob_wb_collector

Overview:
Sits directly upstream of the ROB's branch and exception writeback ports. It takes BRU_NUM branch writebacks and EXC_NUM exception writebacks per cycle. It keeps the oldest mispredicted branch and the oldest exception seen since the last squash. It forwards a single registered branch writeback and a single registered exception writeback, so the ROB only ever sees one of each per cycle.

Parameters:
BRU_NUM, 2, number of branch writeback ports
EXC_NUM, 3, number of exception writeback ports
ROB_SIZE, 64, ROB depth; index width IW = clog2(ROB_SIZE)
XLEN, 64, PC width
EXC_W, 5, exception cause width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_br_vld  in  BRU_NUM  branch writeback valid per port
i_br_info  in  BRU_NUM x branchwbInfo_t  {rob_idx{flipped,idx[IW]}, branch_taken, has_mispred, branch_npc[XLEN]}
i_exc_vld  in  EXC_NUM  exception writeback valid per port
i_exc_info  in  EXC_NUM x exceptwbInfo_t  {rob_idx, except_type[EXC_W]}
i_squash_vld  in  1  pipeline squash from ROB
o_branchwb_vld  out  1  to ROB i_branchwb_vld
o_branchwb_info  out  branchwbInfo_t  to ROB
o_exceptwb_vld  out  1  to ROB i_exceptwb_vld
o_exceptwb_info  out  exceptwbInfo_t  to ROB
o_pending_mispred  out  1  a held mispred exists (debug/perf)
o_pending_except  out  1  a held exception exists

Behaviour:
- Age compare: older(a,b) = (a.flipped==b.flipped) ? (a.idx<b.idx) : (a.idx>b.idx). Equal robIdx is not older.
- Branch candidates: ports with i_br_vld & has_mispred. Non-mispred branch writebacks are ignored (never forwarded).
- Stage 0, combinational: select the oldest branch candidate. On equal robIdx the lower port index wins; an equal robIdx on two valid ports triggers an assertion. The exception side is selected the same way.
- Held registers: br_hold {vld, info} and exc_hold {vld, info}. A candidate updates its hold when hold.vld==0 or older(cand, hold).
- Output: on the cycle after an update, o_*wb_vld=1 for exactly 1 cycle and o_*wb_info = the new hold contents. There is no output when the candidate is not older (latency 1, pulse only on a new oldest).
- Collision: if the selected branch robIdx equals the selected exception robIdx in the same cycle, or equals exc_hold.rob_idx, the branch candidate is dropped. If a newly accepted exception has the same robIdx as br_hold, br_hold is cleared with no output. The ROB therefore never sees a mispred and an exception on the same instruction.
- A branch candidate that is younger than exc_hold is dropped: the exception squashes it anyway.
- Squash: when i_squash_vld=1, both holds are cleared that cycle. All inputs presented in the same cycle are discarded. Outputs registered from the previous cycle still emit, but no new pulse is produced in the following cycle.
- Reset (async): br_hold.vld=0, exc_hold.vld=0, o_branchwb_vld=0, o_exceptwb_vld=0, o_pending_*=0, info regs=0. Reset asserted mid-operation clears everything immediately with no residual pulse.
- Wrap-around: only the flipped bit disambiguates age. ROB occupancy never exceeds ROB_SIZE, so the compare is valid.
- o_pending_mispred=br_hold.vld; o_pending_except=exc_hold.vld (registered).

Decomposition:
- Shared core package: robIdx_t, branchwbInfo_t, exceptwbInfo_t, and an age-compare function rob_older(a,b), also reused by the ROB's bmhr/ehr logic.
- Sub-module oldest_sel #(N, dtype): N-input oldest-valid selector returning {vld, port index}. It is instantiated once for branches and once for exceptions.

Test Plan:
- Single mispred: port1 {flipped0, idx5, npc 0x8000_0100}, hold empty → next cycle o_branchwb_vld=1 with idx5 and npc 0x8000_0100; o_pending_mispred=1.
- Two ports in the same cycle: idx9 and idx3, same flipped → only idx3 forwarded. Then a later idx7 → no output; then idx1 → output idx1.
- Wrap: hold {flipped0, idx60}; input {flipped1, idx2} → not older, no output. Input {flipped0, idx58} → output idx58.
- Collision: mispred idx12 and exception idx12 in the same cycle → only o_exceptwb_vld (idx12) pulses; branch output stays 0. A later mispred idx15 (younger than held exception) is dropped.
- Squash: holds {idx4}; i_squash_vld=1 together with mispred idx2 → no output next cycle, pending=0. Then mispred idx30 → output idx30.
- Async reset asserted between clock edges while holds are valid → all outputs 0 immediately; after release the first mispred is accepted with hold empty.

Source files
------------

// File: rtl/rob_wb_collector_pkg.sv
// Shared ROB writeback types and the wrap-aware age compare.
// The ROB's bmhr/ehr logic reuses the same age compare.
package rob_wb_collector_pkg;

  localparam int ROB_SIZE = 64;
  localparam int IW       = $clog2(ROB_SIZE);
  localparam int XLEN     = 64;
  localparam int EXC_W    = 5;

  typedef struct packed {
    logic          flipped;
    logic [IW-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t         rob_idx;
    logic            branch_taken;
    logic            has_mispred;
    logic [XLEN-1:0] branch_npc;
  } branchwbInfo_t;

  typedef struct packed {
    robIdx_t          rob_idx;
    logic [EXC_W-1:0] except_type;
  } exceptwbInfo_t;

  // Once the pointer has wrapped (flipped bits differ), a larger idx is older.
  // Equal indices are never older.
  function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
    return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/rob_wb_collector_oldest_sel.sv
// N-input oldest-valid selector. On equal age the lower port wins.
// It also flags two valid ports that carry the same ROB index.
module oldest_sel
  import rob_wb_collector_pkg::*;
#(
  parameter int  N  = 2,
  parameter type dtype = robIdx_t,
  parameter int  SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vld,
  input  dtype [N-1:0]  idx,
  output logic          sel_vld,
  output logic [SW-1:0] sel_port,
  output logic          dup
);

  dtype best;

  always_comb begin
    sel_vld  = 1'b0;
    sel_port = '0;
    best     = '0;
    for (int i = 0; i < N; i++) begin
      if (vld[i] && (!sel_vld || rob_older(idx[i], best))) begin
        sel_vld  = 1'b1;
        sel_port = SW'(i);
        best     = idx[i];
      end
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (vld[i] && vld[j] && (idx[i] == idx[j])) dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_wb_collector.sv
// Funnels several branch/exception writebacks into one registered writeback of each.
// It keeps the oldest mispredict and the oldest exception seen since the last squash.
module rob_wb_collector
  import rob_wb_collector_pkg::*;
#(
  parameter int BRU_NUM = 2,
  parameter int EXC_NUM = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic          [BRU_NUM-1:0]  i_br_vld,
  input  branchwbInfo_t [BRU_NUM-1:0]  i_br_info,
  input  logic          [EXC_NUM-1:0]  i_exc_vld,
  input  exceptwbInfo_t [EXC_NUM-1:0]  i_exc_info,
  input  logic                         i_squash_vld,
  output logic                         o_branchwb_vld,
  output branchwbInfo_t                o_branchwb_info,
  output logic                         o_exceptwb_vld,
  output exceptwbInfo_t                o_exceptwb_info,
  output logic                         o_pending_mispred,
  output logic                         o_pending_except
);

  localparam int BSW = (BRU_NUM > 1) ? $clog2(BRU_NUM) : 1;
  localparam int ESW = (EXC_NUM > 1) ? $clog2(EXC_NUM) : 1;

  logic          [BRU_NUM-1:0] br_cand_vld;
  robIdx_t       [BRU_NUM-1:0] br_idx;
  robIdx_t       [EXC_NUM-1:0] exc_idx;
  logic                        br_sel_vld, exc_sel_vld;
  logic          [BSW-1:0]     br_sel_port;
  logic          [ESW-1:0]     exc_sel_port;
  logic                        br_dup, exc_dup;
  branchwbInfo_t               br_cand;
  exceptwbInfo_t               exc_cand;

  logic                        br_hold_vld, exc_hold_vld;
  branchwbInfo_t               br_hold;
  exceptwbInfo_t               exc_hold;

  logic                        exc_accept, br_accept, br_kill;
  robIdx_t                     exc_eff_idx;
  logic                        exc_eff_vld;

  always_comb begin
    br_cand_vld = '0;
    br_idx      = '0;
    exc_idx     = '0;
    for (int i = 0; i < BRU_NUM; i++) begin
      br_cand_vld[i] = i_br_vld[i] & i_br_info[i].has_mispred;
      br_idx[i]      = i_br_info[i].rob_idx;
    end
    for (int i = 0; i < EXC_NUM; i++) exc_idx[i] = i_exc_info[i].rob_idx;
  end

  oldest_sel #(.N(BRU_NUM), .dtype(robIdx_t)) u_br_sel (
    .vld      (br_cand_vld),
    .idx      (br_idx),
    .sel_vld  (br_sel_vld),
    .sel_port (br_sel_port),
    .dup      (br_dup)
  );

  oldest_sel #(.N(EXC_NUM), .dtype(robIdx_t)) u_exc_sel (
    .vld      (i_exc_vld),
    .idx      (exc_idx),
    .sel_vld  (exc_sel_vld),
    .sel_port (exc_sel_port),
    .dup      (exc_dup)
  );

  assign br_cand  = i_br_info[br_sel_port];
  assign exc_cand = i_exc_info[exc_sel_port];

  // A branch is dropped if it shares its ROB entry with an exception, or if it is
  // younger than the oldest exception that will be held after this cycle.
  always_comb begin
    exc_accept  = exc_sel_vld && !i_squash_vld &&
                  (!exc_hold_vld || rob_older(exc_cand.rob_idx, exc_hold.rob_idx));
    exc_eff_vld = exc_accept || exc_hold_vld;
    exc_eff_idx = exc_accept ? exc_cand.rob_idx : exc_hold.rob_idx;
    br_accept   = br_sel_vld && !i_squash_vld &&
                  (!br_hold_vld || rob_older(br_cand.rob_idx, br_hold.rob_idx)) &&
                  !(exc_sel_vld && (br_cand.rob_idx == exc_cand.rob_idx)) &&
                  !(exc_hold_vld && (br_cand.rob_idx == exc_hold.rob_idx)) &&
                  !(exc_eff_vld && rob_older(exc_eff_idx, br_cand.rob_idx));
    br_kill     = exc_accept && br_hold_vld && (exc_cand.rob_idx == br_hold.rob_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_hold_vld    <= 1'b0;
      exc_hold_vld   <= 1'b0;
      br_hold        <= '0;
      exc_hold       <= '0;
      o_branchwb_vld <= 1'b0;
      o_exceptwb_vld <= 1'b0;
    end else begin
      o_branchwb_vld <= br_accept;
      o_exceptwb_vld <= exc_accept;
      if (i_squash_vld) begin
        br_hold_vld  <= 1'b0;
        exc_hold_vld <= 1'b0;
      end else begin
        if (exc_accept) begin
          exc_hold_vld <= 1'b1;
          exc_hold     <= exc_cand;
        end
        if (br_accept) begin
          br_hold_vld <= 1'b1;
          br_hold     <= br_cand;
        end else if (br_kill) begin
          br_hold_vld <= 1'b0;
        end
      end
    end
  end

  assign o_branchwb_info   = br_hold;
  assign o_exceptwb_info   = exc_hold;
  assign o_pending_mispred = br_hold_vld;
  assign o_pending_except  = exc_hold_vld;

  br_no_dup_idx: assert property (@(posedge clk) disable iff (rst) !br_dup)
    else $error("duplicate robIdx on branch writeback ports");
  exc_no_dup_idx: assert property (@(posedge clk) disable iff (rst) !exc_dup)
    else $error("duplicate robIdx on exception writeback ports");

endmodule

// File: tb/tb_rob_wb_collector.sv
// Directed bench for rob_wb_collector with hand-computed expected values.
module tb_rob_wb_collector;
  import rob_wb_collector_pkg::*;

  localparam int BRU_NUM = 2;
  localparam int EXC_NUM = 3;

  logic                        clk;
  logic                        rst;
  logic          [BRU_NUM-1:0] i_br_vld;
  branchwbInfo_t [BRU_NUM-1:0] i_br_info;
  logic          [EXC_NUM-1:0] i_exc_vld;
  exceptwbInfo_t [EXC_NUM-1:0] i_exc_info;
  logic                        i_squash_vld;
  logic                        o_branchwb_vld;
  branchwbInfo_t               o_branchwb_info;
  logic                        o_exceptwb_vld;
  exceptwbInfo_t               o_exceptwb_info;
  logic                        o_pending_mispred;
  logic                        o_pending_except;

  int testsRun = 0;
  int testsFailed = 0;

  rob_wb_collector #(.BRU_NUM(BRU_NUM), .EXC_NUM(EXC_NUM)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_br_vld          (i_br_vld),
    .i_br_info         (i_br_info),
    .i_exc_vld         (i_exc_vld),
    .i_exc_info        (i_exc_info),
    .i_squash_vld      (i_squash_vld),
    .o_branchwb_vld    (o_branchwb_vld),
    .o_branchwb_info   (o_branchwb_info),
    .o_exceptwb_vld    (o_exceptwb_vld),
    .o_exceptwb_info   (o_exceptwb_info),
    .o_pending_mispred (o_pending_mispred),
    .o_pending_except  (o_pending_except)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    i_br_vld     = '0;
    i_br_info    = '0;
    i_exc_vld    = '0;
    i_exc_info   = '0;
    i_squash_vld = 1'b0;
  endtask

  task automatic driveBr(input int p, input logic fl, input int idx, input logic [63:0] npc, input logic mis);
    i_br_vld[p]                  = 1'b1;
    i_br_info[p].rob_idx.flipped = fl;
    i_br_info[p].rob_idx.idx     = IW'(idx);
    i_br_info[p].branch_taken    = 1'b1;
    i_br_info[p].has_mispred     = mis;
    i_br_info[p].branch_npc      = npc;
  endtask

  task automatic driveExc(input int p, input logic fl, input int idx, input int cause);
    i_exc_vld[p]                  = 1'b1;
    i_exc_info[p].rob_idx.flipped = fl;
    i_exc_info[p].rob_idx.idx     = IW'(idx);
    i_exc_info[p].except_type     = EXC_W'(cause);
  endtask

  // Present the driven inputs for one clock edge, then clear them; outputs are stable afterwards.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic squashAll();
    i_squash_vld = 1'b1;
    applyStimulus();
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    #12;
    checkOutput("reset br_vld", 64'(o_branchwb_vld), 64'd0);
    checkOutput("reset exc_vld", 64'(o_exceptwb_vld), 64'd0);
    checkOutput("reset pend_mis", 64'(o_pending_mispred), 64'd0);
    checkOutput("reset pend_exc", 64'(o_pending_except), 64'd0);
    checkOutput("reset br_info", 64'(o_branchwb_info.branch_npc), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single mispredict on port 1.
    driveBr(1, 1'b0, 5, 64'h8000_0100, 1'b1);
    applyStimulus();
    checkOutput("single br_vld", 64'(o_branchwb_vld), 64'd1);
    checkOutput("single idx", 64'(o_branchwb_info.rob_idx), 64'd5);
    checkOutput("single npc", o_branchwb_info.branch_npc, 64'h8000_0100);
    checkOutput("single pend", 64'(o_pending_mispred), 64'd1);
    applyStimulus();
    checkOutput("single pulse ends", 64'(o_branchwb_vld), 64'd0);
    checkOutput("single pend holds", 64'(o_pending_mispred), 64'd1);
    squashAll();
    checkOutput("squash pend clr", 64'(o_pending_mispred), 64'd0);

    // Two ports in one cycle, then a younger and an older follow-up.
    driveBr(0, 1'b0, 9, 64'h900, 1'b1);
    driveBr(1, 1'b0, 3, 64'h300, 1'b1);
    applyStimulus();
    checkOutput("two br_vld", 64'(o_branchwb_vld), 64'd1);
    checkOutput("two idx", 64'(o_branchwb_info.rob_idx), 64'd3);
    checkOutput("two npc", o_branchwb_info.branch_npc, 64'h300);
    driveBr(0, 1'b0, 7, 64'h700, 1'b1);
    applyStimulus();
    checkOutput("younger no out", 64'(o_branchwb_vld), 64'd0);
    checkOutput("younger keep idx", 64'(o_branchwb_info.rob_idx), 64'd3);
    driveBr(0, 1'b0, 1, 64'h100, 1'b1);
    applyStimulus();
    checkOutput("older br_vld", 64'(o_branchwb_vld), 64'd1);
    checkOutput("older idx", 64'(o_branchwb_info.rob_idx), 64'd1);
    // A non-mispredicting branch writeback is never forwarded.
    driveBr(1, 1'b0, 0, 64'h0, 1'b0);
    applyStimulus();
    checkOutput("nomis ignored", 64'(o_branchwb_vld), 64'd0);
    squashAll();

    // Wrap-around: {1,2} is younger than {0,60}; {0,58} is older.
    driveBr(0, 1'b0, 60, 64'h6000, 1'b1);
    applyStimulus();
    checkOutput("wrap base vld", 64'(o_branchwb_vld), 64'd1);
    driveBr(0, 1'b1, 2, 64'h0200, 1'b1);
    applyStimulus();
    checkOutput("wrap flipped no out", 64'(o_branchwb_vld), 64'd0);
    driveBr(1, 1'b0, 58, 64'h5800, 1'b1);
    applyStimulus();
    checkOutput("wrap older vld", 64'(o_branchwb_vld), 64'd1);
    checkOutput("wrap older idx", 64'(o_branchwb_info.rob_idx), 64'd58);
    squashAll();

    // Same-cycle collision: the exception wins and the branch is dropped.
    driveBr(0, 1'b0, 12, 64'hC00, 1'b1);
    driveExc(2, 1'b0, 12, 5);
    applyStimulus();
    checkOutput("coll exc_vld", 64'(o_exceptwb_vld), 64'd1);
    checkOutput("coll exc idx", 64'(o_exceptwb_info.rob_idx), 64'd12);
    checkOutput("coll exc type", 64'(o_exceptwb_info.except_type), 64'd5);
    checkOutput("coll br_vld", 64'(o_branchwb_vld), 64'd0);
    checkOutput("coll pend_mis", 64'(o_pending_mispred), 64'd0);
    checkOutput("coll pend_exc", 64'(o_pending_except), 64'd1);
    driveBr(1, 1'b0, 15, 64'hF00, 1'b1);
    applyStimulus();
    checkOutput("young br dropped", 64'(o_branchwb_vld), 64'd0);
    checkOutput("young br no pend", 64'(o_pending_mispred), 64'd0);
    squashAll();
    checkOutput("squash pend_exc", 64'(o_pending_except), 64'd0);

    // A new exception on the held branch's entry silently clears the branch hold.
    driveBr(0, 1'b0, 20, 64'h2000, 1'b1);
    applyStimulus();
    checkOutput("kill setup br", 64'(o_branchwb_vld), 64'd1);
    driveExc(0, 1'b0, 20, 3);
    applyStimulus();
    checkOutput("kill exc_vld", 64'(o_exceptwb_vld), 64'd1);
    checkOutput("kill br_vld", 64'(o_branchwb_vld), 64'd0);
    checkOutput("kill pend_mis", 64'(o_pending_mispred), 64'd0);
    squashAll();

    // Squash discards same-cycle inputs.
    driveBr(0, 1'b0, 4, 64'h400, 1'b1);
    applyStimulus();
    checkOutput("sq setup vld", 64'(o_branchwb_vld), 64'd1);
    driveBr(1, 1'b0, 2, 64'h200, 1'b1);
    i_squash_vld = 1'b1;
    applyStimulus();
    checkOutput("sq no out", 64'(o_branchwb_vld), 64'd0);
    checkOutput("sq pend", 64'(o_pending_mispred), 64'd0);
    driveBr(0, 1'b0, 30, 64'h3000, 1'b1);
    applyStimulus();
    checkOutput("post sq vld", 64'(o_branchwb_vld), 64'd1);
    checkOutput("post sq idx", 64'(o_branchwb_info.rob_idx), 64'd30);

    // Async reset between edges while both holds are valid.
    driveExc(1, 1'b0, 8, 2);
    applyStimulus();
    checkOutput("pre rst exc_vld", 64'(o_exceptwb_vld), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async br_vld", 64'(o_branchwb_vld), 64'd0);
    checkOutput("async exc_vld", 64'(o_exceptwb_vld), 64'd0);
    checkOutput("async pend_mis", 64'(o_pending_mispred), 64'd0);
    checkOutput("async pend_exc", 64'(o_pending_except), 64'd0);
    checkOutput("async exc info", 64'(o_exceptwb_info.rob_idx), 64'd0);
    #1;
    rst = 1'b0;
    driveBr(1, 1'b1, 50, 64'h5000, 1'b1);
    applyStimulus();
    checkOutput("after rst vld", 64'(o_branchwb_vld), 64'd1);
    checkOutput("after rst idx", 64'(o_branchwb_info.rob_idx), 64'h72);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
